// File: rtl/load_store_unit_if.sv
// CPU-side request/response and word-memory handshake of the load/store unit.
// slave = the LSU itself; master = whoever drives the pipeline and the memory.
interface load_store_unit_if;
  logic [3:0]  cpu_read;
  logic [2:0]  cpu_write;
  logic [31:0] cpu_address;
  logic [31:0] cpu_writedata;
  logic [31:0] cpu_readdata;
  logic        cpu_busywait;
  logic        misaligned;
  logic [3:0]  mem_read;
  logic [2:0]  mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_busywait;

  modport slave (
    input  cpu_read, cpu_write, cpu_address, cpu_writedata, mem_readdata, mem_busywait,
    output cpu_readdata, cpu_busywait, misaligned, mem_read, mem_write, mem_address, mem_writedata
  );

  modport master (
    output cpu_read, cpu_write, cpu_address, cpu_writedata, mem_readdata, mem_busywait,
    input  cpu_readdata, cpu_busywait, misaligned, mem_read, mem_write, mem_address, mem_writedata
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32 load/store bridge onto a word-only memory: lane select/extend for loads,
// read-modify-write for SB/SH, optional misalignment trap.
module load_store_unit #(
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic               clock,
  input  logic               reset,
  load_store_unit_if.slave   bus
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_ALIGN, S_WR, S_DONE} state_t;

  state_t      r_state, w_next;
  logic        r_is_load, r_err;
  logic [2:0]  r_f3;
  logic [31:0] r_addr, r_wdata, r_rdata;

  logic        w_rd_req, w_wr_req, w_valid, w_mis, w_subword;
  logic [1:0]  w_size;
  logic [31:0] w_shift, w_load, w_merge;

  assign w_rd_req  = bus.cpu_read[3];
  assign w_wr_req  = bus.cpu_write[2];
  assign w_valid   = w_rd_req ^ w_wr_req;
  assign w_size    = w_rd_req ? bus.cpu_read[1:0] : bus.cpu_write[1:0];
  assign w_subword = ~w_size[1];
  assign w_mis     = ALIGN_CHECK &&
                     (((w_size == 2'b01) && bus.cpu_address[0]) ||
                      (w_size[1] && (bus.cpu_address[1:0] != 2'b00)));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_valid) begin
                 if (w_mis)                      w_next = S_DONE;
                 else if (w_rd_req || w_subword) w_next = S_RD;
                 else                            w_next = S_WR;
               end
      S_RD:    if (!bus.mem_busywait) w_next = S_ALIGN;
      S_ALIGN: w_next = r_is_load ? S_DONE : S_WR;
      S_WR:    if (!bus.mem_busywait) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Lane extraction: shift the addressed byte/halfword down to bit 0.
  assign w_shift = bus.mem_readdata >> {r_addr[1:0], 3'b000};

  always_comb begin
    w_load = bus.mem_readdata;
    case (r_f3)
      3'b000:  w_load = {{24{w_shift[7]}}, w_shift[7:0]};
      3'b100:  w_load = {24'd0, w_shift[7:0]};
      3'b001:  w_load = r_addr[1] ? {{16{bus.mem_readdata[31]}}, bus.mem_readdata[31:16]}
                                  : {{16{bus.mem_readdata[15]}}, bus.mem_readdata[15:0]};
      3'b101:  w_load = r_addr[1] ? {16'd0, bus.mem_readdata[31:16]}
                                  : {16'd0, bus.mem_readdata[15:0]};
      default: w_load = bus.mem_readdata;
    endcase
  end

  always_comb begin
    w_merge = bus.mem_readdata;
    case (r_f3[1:0])
      2'b00:   w_merge[{r_addr[1:0], 3'b000} +: 8]  = r_wdata[7:0];
      2'b01:   w_merge[{r_addr[1], 4'b0000} +: 16]  = r_wdata[15:0];
      default: w_merge = r_wdata;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_is_load <= 1'b0;
      r_err     <= 1'b0;
      r_f3      <= 3'd0;
      r_addr    <= 32'd0;
      r_wdata   <= 32'd0;
      r_rdata   <= 32'd0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (w_valid) begin
          r_is_load <= w_rd_req;
          r_f3      <= w_rd_req ? bus.cpu_read[2:0] : {1'b0, bus.cpu_write[1:0]};
          r_addr    <= bus.cpu_address;
          r_wdata   <= bus.cpu_writedata;
          r_err     <= w_mis;
          if (w_mis && w_rd_req) r_rdata <= 32'd0;
        end
        // r_wdata doubles as the merged RMW word so it stays put during WR stalls.
        S_ALIGN: begin
          if (r_is_load) r_rdata <= w_load;
          else           r_wdata <= w_merge;
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_read      = (!reset && r_state == S_RD) ? 4'b1010 : 4'b0000;
  assign bus.mem_write     = (!reset && r_state == S_WR) ? 3'b110  : 3'b000;
  assign bus.mem_address   = {r_addr[31:2], 2'b00};
  assign bus.mem_writedata = r_wdata;
  assign bus.cpu_readdata  = r_rdata;
  assign bus.misaligned    = (r_state == S_DONE) && r_err;
  assign bus.cpu_busywait  = !reset && (((r_state == S_IDLE) && w_valid) ||
                                        (r_state == S_RD) || (r_state == S_ALIGN) ||
                                        (r_state == S_WR));

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed table from the plan, hand sequences for
// reset-abort and double-valid, then random ops against a byte-level memory model.
module tb_load_store_unit;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  load_store_unit_if bus();
  load_store_unit #(.ALIGN_CHECK(1'b1)) dut (.clock(clock), .reset(reset), .bus(bus.slave));

  // ---------------- word memory with injectable stalls ----------------
  logic [31:0] mem [0:63] = '{default: 32'h02020202};
  logic [31:0] rdata_q = 32'd0;
  int busy_rd = 0, busy_wr = 0;
  int stall_cnt = 0, n_rd_acc = 0, n_wr_acc = 0, n_rd_strb = 0, n_wr_strb = 0;
  int unstable = 0;
  logic        stall_seen = 1'b0;
  logic [31:0] prev_addr = 32'd0, prev_wd = 32'd0;
  logic rd_s, wr_s;

  assign rd_s = (bus.mem_read == 4'b1010);
  assign wr_s = (bus.mem_write == 3'b110);
  assign bus.mem_busywait = (rd_s && stall_cnt < busy_rd) || (wr_s && stall_cnt < busy_wr);
  assign bus.mem_readdata = rdata_q;

  always @(posedge clock) begin
    if ((rd_s || wr_s) && bus.mem_busywait) stall_cnt <= stall_cnt + 1;
    else                                    stall_cnt <= 0;
    if (rd_s) n_rd_strb <= n_rd_strb + 1;
    if (wr_s) n_wr_strb <= n_wr_strb + 1;
    if (rd_s && !bus.mem_busywait) begin
      rdata_q  <= mem[bus.mem_address[7:2]];
      n_rd_acc <= n_rd_acc + 1;
    end
    if (wr_s && !bus.mem_busywait) begin
      mem[bus.mem_address[7:2]] <= bus.mem_writedata;
      n_wr_acc <= n_wr_acc + 1;
    end
    stall_seen <= bus.mem_busywait;
    prev_addr  <= bus.mem_address;
    prev_wd    <= bus.mem_writedata;
    if (stall_seen && (bus.mem_address != prev_addr || bus.mem_writedata != prev_wd))
      unstable <= unstable + 1;
  end

  // ---------------- checking ----------------
  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  // ---------------- reference model: byte-addressed memory ----------------
  logic [7:0]  ref_b [0:255];
  logic [31:0] last_rd = 32'd0;

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit m_mis(input logic [2:0] f3, input logic [31:0] a);
    int n = nbytes(f3[1:0]);
    return (a % n) != 0;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a);
    int n = nbytes(f3[1:0]);
    logic [31:0] v = 32'd0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_b[(a + i) & 255]) << (8 * i));
    if (!f3[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFFFFFF << (8 * n));
    return v;
  endfunction

  function automatic int m_lat(input bit ld, input logic [2:0] f3, input logic [31:0] a,
                               input int brd, input int bwr);
    if (m_mis(f3, a)) return 1;
    if (ld) return 3 + brd;
    if (f3[1:0] == 2'b10) return 2 + bwr;
    return 4 + brd + bwr;
  endfunction

  task automatic m_apply(input bit ld, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d);
    if (ld) last_rd = m_mis(f3, a) ? 32'd0 : m_load(f3, a);
    else if (!m_mis(f3, a))
      for (int i = 0; i < nbytes(f3[1:0]); i++) ref_b[(a + i) & 255] = d[8*i +: 8];
  endtask

  // ---------------- one request, start to DONE ----------------
  task automatic do_op(input string tag, input bit ld, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d, input int brd,
                       input int bwr, input logic [31:0] exp_rd, input bit exp_mis,
                       input int exp_lat);
    int rd0, wr0, lat, erd, ewr;
    bit done;
    rd0 = n_rd_acc; wr0 = n_wr_acc;
    @(negedge clock);
    busy_rd = brd; busy_wr = bwr;
    bus.cpu_read      = ld ? {1'b1, f3} : 4'b0000;
    bus.cpu_write     = ld ? 3'b000 : {1'b1, f3[1:0]};
    bus.cpu_address   = a;
    bus.cpu_writedata = d;
    lat = 0; done = 0;
    while (!done && lat < 30) begin
      #1;
      if (!bus.cpu_busywait) done = 1;
      else begin @(negedge clock); lat++; end
    end
    if (!done) chk({tag, " timeout"}, 32'(lat), 32'(exp_lat));
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " misaligned"}, {31'd0, bus.misaligned}, {31'd0, exp_mis});
    chk({tag, " readdata"}, bus.cpu_readdata, exp_rd);
    bus.cpu_read = 4'b0000; bus.cpu_write = 3'b000;
    @(posedge clock); #1;
    erd = (exp_mis || (!ld && f3[1:0] == 2'b10)) ? 0 : 1;
    ewr = (exp_mis || ld) ? 0 : 1;
    chk({tag, " mem reads"}, 32'(n_rd_acc - rd0), 32'(erd));
    chk({tag, " mem writes"}, 32'(n_wr_acc - wr0), 32'(ewr));
    busy_rd = 0; busy_wr = 0;
  endtask

  typedef struct {
    bit          ld;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] data;
    int          brd;
    int          bwr;
    logic [31:0] exp_rd;
    bit          exp_mis;
    int          exp_lat;
  } vec_t;

  vec_t tbl [16];

  initial begin
    int ws0, rs0;
    logic [2:0] lf3 [5];
    for (int i = 0; i < 256; i++) ref_b[i] = 8'h02;
    lf3[0] = 3'b000; lf3[1] = 3'b001; lf3[2] = 3'b010; lf3[3] = 3'b100; lf3[4] = 3'b101;

    tbl[0]  = '{1, 3'b000, 32'h05, 32'h0,        0, 0, 32'h00000002, 0, 3};
    tbl[1]  = '{0, 3'b000, 32'h06, 32'h80,       0, 0, 32'h00000002, 0, 4};
    tbl[2]  = '{1, 3'b000, 32'h06, 32'h0,        0, 0, 32'hFFFFFF80, 0, 3};
    tbl[3]  = '{1, 3'b100, 32'h06, 32'h0,        0, 0, 32'h00000080, 0, 3};
    tbl[4]  = '{1, 3'b010, 32'h04, 32'h0,        0, 0, 32'h02800202, 0, 3};
    tbl[5]  = '{0, 3'b001, 32'h0A, 32'hBEEF,     0, 0, 32'h02800202, 0, 4};
    tbl[6]  = '{1, 3'b001, 32'h0A, 32'h0,        0, 0, 32'hFFFFBEEF, 0, 3};
    tbl[7]  = '{1, 3'b010, 32'h08, 32'h0,        0, 0, 32'hBEEF0202, 0, 3};
    tbl[8]  = '{0, 3'b010, 32'h10, 32'h12345678, 0, 0, 32'hBEEF0202, 0, 2};
    tbl[9]  = '{1, 3'b010, 32'h10, 32'h0,        0, 0, 32'h12345678, 0, 3};
    tbl[10] = '{1, 3'b010, 32'h02, 32'h0,        0, 0, 32'h00000000, 1, 1};
    tbl[11] = '{0, 3'b001, 32'h03, 32'hAAAA,     0, 0, 32'h00000000, 1, 1};
    tbl[12] = '{1, 3'b000, 32'h05, 32'h0,        3, 0, 32'h00000002, 0, 6};
    tbl[13] = '{1, 3'b101, 32'h0A, 32'h0,        0, 0, 32'h0000BEEF, 0, 3};
    tbl[14] = '{0, 3'b000, 32'h13, 32'h11,       1, 2, 32'h0000BEEF, 0, 7};
    tbl[15] = '{1, 3'b010, 32'h10, 32'h0,        0, 0, 32'h11345678, 0, 3};

    bus.cpu_read = 4'b0000; bus.cpu_write = 3'b000;
    bus.cpu_address = 32'd0; bus.cpu_writedata = 32'd0;

    // reset values, busywait forced low even with a request pending
    repeat (2) @(negedge clock);
    bus.cpu_read = 4'b1010; #1;
    chk("rst busywait", {31'd0, bus.cpu_busywait}, 32'd0);
    bus.cpu_read = 4'b0000;
    chk("rst readdata", bus.cpu_readdata, 32'd0);
    chk("rst mem_addr", bus.mem_address, 32'd0);
    chk("rst mem_wdata", bus.mem_writedata, 32'd0);
    chk("rst strobes", {25'd0, bus.mem_read, bus.mem_write}, 32'd0);
    @(negedge clock); reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      do_op($sformatf("vec%0d", i), tbl[i].ld, tbl[i].f3, tbl[i].addr, tbl[i].data,
            tbl[i].brd, tbl[i].bwr, tbl[i].exp_rd, tbl[i].exp_mis, tbl[i].exp_lat);
      m_apply(tbl[i].ld, tbl[i].f3, tbl[i].addr, tbl[i].data);
    end
    chk("addr stable in stalls", 32'(unstable), 32'd0);

    // reset during ALIGN of an SB: the RMW must never write
    ws0 = n_wr_strb;
    @(negedge clock);
    bus.cpu_write = 3'b100; bus.cpu_address = 32'h20; bus.cpu_writedata = 32'h55;
    @(negedge clock);                 // RD
    @(negedge clock);                 // ALIGN
    reset = 1'b1; bus.cpu_write = 3'b000; #1;
    chk("abort busywait", {31'd0, bus.cpu_busywait}, 32'd0);
    @(negedge clock);
    chk("abort readdata", bus.cpu_readdata, 32'd0);
    chk("abort mem_addr", bus.mem_address, 32'd0);
    chk("abort mem_wdata", bus.mem_writedata, 32'd0);
    chk("abort strobes", {24'd0, bus.misaligned, bus.mem_read, bus.mem_write}, 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    chk("abort no write strobe", 32'(n_wr_strb - ws0), 32'd0);
    chk("abort word", mem[8], {ref_b[35], ref_b[34], ref_b[33], ref_b[32]});
    last_rd = 32'd0;

    // load and store valid together: ignored
    rs0 = n_rd_strb; ws0 = n_wr_strb;
    bus.cpu_read = 4'b1010; bus.cpu_write = 3'b110; bus.cpu_address = 32'h30;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("both busywait c%0d", i), {31'd0, bus.cpu_busywait}, 32'd0);
      @(negedge clock);
    end
    bus.cpu_read = 4'b0000; bus.cpu_write = 3'b000;
    chk("both no strobes", 32'((n_rd_strb - rs0) + (n_wr_strb - ws0)), 32'd0);

    // randomized ops against the byte model
    for (int i = 0; i < 60; i++) begin
      bit ld;
      logic [2:0] f3;
      logic [31:0] a, d;
      int brd, bwr;
      ld  = $urandom_range(0, 1) == 1;
      f3  = ld ? lf3[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
      a   = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) a[0] = 1'b0;
      if ($urandom_range(0, 2) != 0) a[1] = 1'b0;
      d   = $urandom;
      brd = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      bwr = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      m_apply(ld, f3, a, d);
      do_op($sformatf("rnd%0d", i), ld, f3, a, d, brd, bwr, last_rd, m_mis(f3, a),
            m_lat(ld, f3, a, brd, bwr));
    end
    chk("addr stable in stalls (rnd)", 32'(unstable), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
